mux_serializer: RTL and testbench
=================================

MUX_SERIALIZER -- requirements
Module: mux_serializer

Interface
- REQ-001: The block SHALL have one clock, clk; reset SHALL be synchronous and active-high, named reset.
- REQ-002: Parameter MSB_FIRST, default 0, selects bit order: 0 sends bit 0 first, 1 sends bit 7 first.
- REQ-003: clk, input, 1, rising-edge clock for all state.
- REQ-004: reset, input, 1, synchronous active-high reset.
- REQ-005: start, input, 1, request to load data and begin a frame.
- REQ-006: data, input, 8, parallel word sampled on an accepted start.
- REQ-007: out_ready, input, 1, downstream accepts sbit this cycle.
- REQ-008: sel, output, 3, current bit index; wires {s2,s1,s0} of the 8:1 mux stage.
- REQ-009: sbit, output, 1, current serial bit.
- REQ-010: out_valid, output, 1, sbit is valid.
- REQ-011: busy, output, 1, high in every state except IDLE.
- REQ-012: done, output, 1, one-cycle pulse at frame end.

Function
- REQ-013: The FSM SHALL have states IDLE, SHIFT, PARITY and DONE; PARITY exists only per REQ-027.
- REQ-014: In IDLE, start=1 SHALL latch data into an 8-bit holding register and set sel to 0, or to 7 when MSB_FIRST=1; the next state is SHIFT.
- REQ-015: start SHALL be ignored in SHIFT, PARITY and DONE; data SHALL NOT be re-sampled until the next accepted start.
- REQ-016: In SHIFT, out_valid=1 and sbit SHALL equal holding_reg[sel] combinationally.
- REQ-017: A transfer SHALL occur only on a cycle with out_valid=1 and out_ready=1; sel SHALL advance by +1, or by -1 when MSB_FIRST=1, only on a transfer.
- REQ-018: While out_ready=0, sel, sbit and out_valid SHALL hold steady, with no timeout.
- REQ-019: A transfer of the 8th bit (sel=7, or sel=0 when MSB_FIRST=1) SHALL move the FSM to PARITY if enabled, otherwise to DONE; sel SHALL NOT wrap within a frame.
- REQ-020: In DONE, done=1, out_valid=0 and busy=1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
- REQ-021: In IDLE, out_valid=0, done=0, busy=0, and sbit SHALL be 0.
- REQ-022: Latency with out_ready held at 1: start sampled in cycle N; bits valid in cycles N+1 to N+8; done in N+9 (N+10 with parity); next start accepted in N+10 (N+11 with parity).

Reset
- REQ-023: reset=1 SHALL force IDLE, sel=0, holding register=0, sbit=0, out_valid=0, busy=0 and done=0 on the next clk edge.
- REQ-024: reset SHALL take priority over start and over transfers in the same cycle.
- REQ-025: A reset in the middle of a frame SHALL abort it with no done pulse; the first start after reset SHALL begin a fresh frame.

Configuration
- REQ-026: Macro MUX_SERIALIZER_PARITY_EN SHALL compile the parity feature in or out.
- REQ-027: With MUX_SERIALIZER_PARITY_EN defined:
  - After the 8th transfer, the FSM SHALL enter PARITY.
  - In PARITY, out_valid=1 and sbit = XOR of the holding register (even parity).
  - PARITY SHALL wait for out_ready like SHIFT, then go to DONE.
  - sel SHALL hold its final value during PARITY.
- REQ-028: Without MUX_SERIALIZER_PARITY_EN, the PARITY state and its logic SHALL be absent and frames SHALL be exactly 8 bits.

Verification
- REQ-029: reset=1 for 2 cycles with start=1 and data=8'hFF -> all outputs 0, busy=0, no frame starts.
- REQ-030: MSB_FIRST=0, data=8'hB4, out_ready=1 -> sbit sequence 0,0,1,0,1,1,0,1 with sel 0 to 7; done in N+9 (parity build: 9th bit=0, done in N+10).
- REQ-031: MSB_FIRST=1, data=8'h81, out_ready=1 -> sbit 1,0,0,0,0,0,0,1 with sel 7 down to 0 (parity build: 9th bit=0).
- REQ-032: data=8'h0F, out_ready=0 for 3 cycles at sel=2 -> sel=2, sbit=1 and out_valid=1 held for those 3 cycles; frame completes correctly afterwards.
- REQ-033: start=1 and data=8'h00 pulsed during SHIFT of an 8'hA5 frame -> ignored; serialized bits remain 8'hA5 (parity build: 9th bit=0).
- REQ-034: reset asserted at sel=4 -> next cycle IDLE with no done pulse; start with data=8'h01 then produces a full correct frame.

Source files
------------

// File: rtl/mux_serializer.sv
// mux_serializer: loads a byte on start and shifts it out through an 8:1 mux select, LSB or MSB first.
// Define MUX_SERIALIZER_PARITY_EN to append an even-parity bit after the eighth data bit.
module mux_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       out_ready,
    output logic [2:0] sel,
    output logic       sbit,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);
`ifdef MUX_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] sel_q, sel_d;
    logic       last;

    assign sel  = sel_q;
    assign last = MSB_FIRST ? (sel_q == 3'd0) : (sel_q == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= 8'h00;
            sel_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        sel_d     = sel_q;
        out_valid = 1'b0;
        sbit      = 1'b0;
        done      = 1'b0;
        busy      = state_q != IDLE;
        case (state_q)
            IDLE: if (start) begin
                hold_d  = data;
                sel_d   = MSB_FIRST ? 3'd7 : 3'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                out_valid = 1'b1;
                sbit      = hold_q[sel_q];
                // sel parks on the last index rather than wrapping
                if (out_ready) begin
`ifdef MUX_SERIALIZER_PARITY_EN
                    if (last) state_d = PARITY;
`else
                    if (last) state_d = DONE;
`endif
                    else sel_d = MSB_FIRST ? sel_q - 3'd1 : sel_q + 3'd1;
                end
            end
`ifdef MUX_SERIALIZER_PARITY_EN
            PARITY: begin
                out_valid = 1'b1;
                sbit      = ^hold_q;
                if (out_ready) state_d = DONE;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer: directed bench driving an LSB-first and an MSB-first instance side by side.
module tb_mux_serializer;
    logic       clk = 1'b0;
    logic       reset, start, out_ready;
    logic [7:0] data;
    logic [2:0] sel0, sel1;
    logic       sbit0, sbit1, ov0, ov1, busy0, busy1, done0, done1;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    mux_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .start(start), .data(data), .out_ready(out_ready),
        .sel(sel0), .sbit(sbit0), .out_valid(ov0), .busy(busy0), .done(done0)
    );
    mux_serializer #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .start(start), .data(data), .out_ready(out_ready),
        .sel(sel1), .sbit(sbit1), .out_valid(ov1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " ov0"}, 8'(ov0), 8'd0);
        chk({tag, " sbit0"}, 8'(sbit0), 8'd0);
        chk({tag, " busy0"}, 8'(busy0), 8'd0);
        chk({tag, " done0"}, 8'(done0), 8'd0);
        chk({tag, " busy1"}, 8'(busy1), 8'd0);
        chk({tag, " ov1"}, 8'(ov1), 8'd0);
    endtask

    // rev is the hand-computed MSB-first bit stream, captured in transmit order
    task automatic frame(input logic [7:0] d, input logic [7:0] rev, input int stall_at, input int inj_at);
        logic [7:0] got0, got1;
        start = 1'b1;
        data  = d;
        tick();
        start = 1'b0;
        data  = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("sel0[%0d]", i), 8'(sel0), 8'(i));
            chk($sformatf("sel1[%0d]", i), 8'(sel1), 8'(7 - i));
            chk($sformatf("ov[%0d]", i), {6'd0, ov0, ov1}, 8'd3);
            chk($sformatf("busy[%0d]", i), {6'd0, busy0, busy1}, 8'd3);
            got0[i] = sbit0;
            got1[i] = sbit1;
            if (i == inj_at) begin
                start = 1'b1;
                data  = 8'h00;
            end
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk($sformatf("stall sel0[%0d]", k), 8'(sel0), 8'(i));
                    chk($sformatf("stall sbit0[%0d]", k), 8'(sbit0), 8'(d[i]));
                    chk($sformatf("stall ov0[%0d]", k), 8'(ov0), 8'd1);
                    chk($sformatf("stall sel1[%0d]", k), 8'(sel1), 8'(7 - i));
                end
                out_ready = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        chk("stream lsb", got0, d);
        chk("stream msb", got1, rev);
`ifdef MUX_SERIALIZER_PARITY_EN
        chk("parity ov", {6'd0, ov0, ov1}, 8'd3);
        chk("parity sbit0", 8'(sbit0), 8'(^d));
        chk("parity sbit1", 8'(sbit1), 8'(^d));
        chk("parity sel0", 8'(sel0), 8'd7);
        tick();
`endif
        chk("done pulse", {6'd0, done0, done1}, 8'd3);
        chk("done busy", {6'd0, busy0, busy1}, 8'd3);
        chk("done ov", {6'd0, ov0, ov1}, 8'd0);
        tick();
        chk_idle("post frame");
        chk("post done", {6'd0, done0, done1}, 8'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b1;
        data      = 8'hFF;
        out_ready = 1'b1;
        tick();
        tick();
        chk_idle("reset");
        chk("reset sel0", 8'(sel0), 8'd0);
        chk("reset sel1", 8'(sel1), 8'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk_idle("after reset");

        frame(8'hB4, 8'h2D, -1, -1);
        frame(8'h81, 8'h81, -1, -1);
        frame(8'h0F, 8'hF0, 2, -1);
        frame(8'hA5, 8'hA5, -1, 3);

        start = 1'b1;
        data  = 8'h3C;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("abort sel0", 8'(sel0), 8'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("abort");
        chk("abort sel0 cleared", 8'(sel0), 8'd0);
        chk("abort done1", 8'(done1), 8'd0);
        tick();
        chk_idle("abort settle");
        frame(8'h01, 8'h80, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
